// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage chain: stage-register select codes,
// the NOP payload value and the occupancy width helper.
package pipe_pkg;

    localparam int unsigned NOP_PAYLOAD = 0;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_CLEAR = 2'd2
    } stage_sel_e;

    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register ({valid, payload}) with load/hold/clear select
// and asynchronous active-low reset.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  stage_sel_e   sel,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        case (sel)
            SEL_LOAD:  state_d = d;
            SEL_CLEAR: state_d = W'(NOP_PAYLOAD);
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of valid-tagged pipeline registers with stall (hold plus
// bubble), flush (kill younger stages) and saturating stall/flush counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 96,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    input  logic [STAGES-1:0]              stall,
    input  logic [STAGES-1:0]              flush,
    input  logic                           clear_counters,
    output logic [STAGES-1:0]              stage_valid,
    output logic [STAGES*WIDTH-1:0]        stage_data,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(STAGES)-1:0]   occupancy,
    output logic [CNT_W-1:0]               stall_count,
    output logic [CNT_W-1:0]               flush_count
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;
    logic [WIDTH:0]    stage_bits [STAGES];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [OCC_W-1:0]  occ;

    // Suffix-OR from the oldest stage down: a stall or flush affects itself and all younger stages.
    always_comb begin
        hold = '0;
        kill = '0;
        hold[STAGES-1] = stall[STAGES-1];
        kill[STAGES-1] = flush[STAGES-1];
        for (int unsigned i = 1; i < STAGES; i++) begin
            hold[STAGES-1-i] = hold[STAGES-i] | stall[STAGES-1-i];
            kill[STAGES-1-i] = kill[STAGES-i] | flush[STAGES-1-i];
        end
    end

    assign in_ready = !hold[0] && !(|flush);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_sel_e     sel;
        logic [WIDTH:0] load;

        if (k == 0) begin : g_head
            always_comb begin
                sel  = SEL_LOAD;
                load = {in_valid, in_valid ? in_data : WIDTH'(NOP_PAYLOAD)};
                if (kill[0]) begin
                    sel = SEL_CLEAR;
                end else if (hold[0]) begin
                    sel = SEL_HOLD;
                end
            end
        end else begin : g_body
            always_comb begin
                sel  = SEL_LOAD;
                load = stage_bits[k-1];
                if (kill[k]) begin
                    sel = SEL_CLEAR;
                end else if (hold[k]) begin
                    sel = SEL_HOLD;
                end else if (hold[k-1] || kill[k-1]) begin
                    sel = SEL_CLEAR;
                end
            end
        end

        pipe_stage_reg #(
            .W (WIDTH + 1)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .sel   (sel),
            .d     (load),
            .q     (stage_bits[k])
        );

        assign stage_valid[k]               = stage_bits[k][WIDTH];
        assign stage_data[k*WIDTH +: WIDTH] = stage_bits[k][WIDTH-1:0];
    end

    assign out_valid = stage_bits[STAGES-1][WIDTH];
    assign out_data  = stage_bits[STAGES-1][WIDTH-1:0];

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(stage_valid[i]);
        end
    end

    assign occupancy = occ;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clear_counters) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (|stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
            if (|flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=8, STAGES=4, CNT_W=4): vector
// table from a full chain, hand sequences, and random traffic against a model.
module tb_pipe_stage_chain;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        clear_counters;
    logic [3:0]  stage_valid;
    logic [31:0] stage_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  occupancy;
    logic [3:0]  stall_count;
    logic [3:0]  flush_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: stage k valid/payload plus counters
    logic       mv [4];
    logic [7:0] md [4];
    int         msc;
    int         mfc;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  fl;
        logic        iv;
        logic [7:0]  id;
        logic        rdy;
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } vec_t;

    vec_t tbl [8];

    pipe_stage_chain #(
        .WIDTH  (8),
        .STAGES (4),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .stall          (stall),
        .flush          (flush),
        .clear_counters (clear_counters),
        .stage_valid    (stage_valid),
        .stage_data     (stage_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .occupancy      (occupancy),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        msc = 0;
        mfc = 0;
    endtask

    // Highest flushed index clears everything at or below it; highest stalled
    // index freezes everything at or below it; the stage just above a frozen
    // or killed one receives an empty slot.
    task automatic model_step(input logic [3:0] st, input logic [3:0] fl,
                              input logic iv, input logic [7:0] id, input logic clr);
        int         fmax = -1;
        int         smax = -1;
        logic       nv [4];
        logic [7:0] nd [4];
        for (int k = 0; k < 4; k++) begin
            if (fl[k]) fmax = k;
            if (st[k]) smax = k;
        end
        for (int k = 0; k < 4; k++) begin
            if (k <= fmax) begin
                nv[k] = 1'b0; nd[k] = 8'h00;
            end else if (k <= smax) begin
                nv[k] = mv[k]; nd[k] = md[k];
            end else if (k == 0) begin
                nv[k] = iv; nd[k] = iv ? id : 8'h00;
            end else if (k - 1 == smax || k - 1 == fmax) begin
                nv[k] = 1'b0; nd[k] = 8'h00;
            end else begin
                nv[k] = mv[k-1]; nd[k] = md[k-1];
            end
        end
        for (int k = 0; k < 4; k++) begin
            mv[k] = nv[k];
            md[k] = nd[k];
        end
        if (clr) begin
            msc = 0;
            mfc = 0;
        end else begin
            if (st != 0 && msc < 15) msc++;
            if (fl != 0 && mfc < 15) mfc++;
        end
    endtask

    task automatic check_model();
        logic [3:0]  ev;
        logic [31:0] ed;
        int          occ = 0;
        for (int k = 0; k < 4; k++) begin
            ev[k]          = mv[k];
            ed[k*8 +: 8]   = md[k];
            occ           += int'(mv[k]);
        end
        chk("stage_valid", 32'(stage_valid), 32'(ev));
        chk("stage_data", stage_data, ed);
        chk("out_valid", 32'(out_valid), 32'(mv[3]));
        chk("out_data", 32'(out_data), 32'(md[3]));
        chk("occupancy", 32'(occupancy), occ);
        chk("stall_count", 32'(stall_count), msc);
        chk("flush_count", 32'(flush_count), mfc);
    endtask

    task automatic drive(input logic [3:0] st, input logic [3:0] fl,
                         input logic iv, input logic [7:0] id, input logic clr);
        stall          = st;
        flush          = fl;
        in_valid       = iv;
        in_data        = id;
        clear_counters = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rcycle(input logic [3:0] st, input logic [3:0] fl,
                          input logic iv, input logic [7:0] id, input logic clr);
        drive(st, fl, iv, id, clr);
        #1;
        chk("in_ready", 32'(in_ready), 32'(st == 4'b0 && fl == 4'b0));
        tick();
        model_step(st, fl, iv, id, clr);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'b0, 4'b0, 1'b0, 8'h00, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill_abcd();
        do_reset();
        rcycle(4'b0, 4'b0, 1'b1, 8'hAA, 1'b0);
        rcycle(4'b0, 4'b0, 1'b1, 8'hBB, 1'b0);
        rcycle(4'b0, 4'b0, 1'b1, 8'hCC, 1'b0);
        rcycle(4'b0, 4'b0, 1'b1, 8'hDD, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        drive(4'b0, 4'b0, 1'b0, 8'h00, 1'b0);

        // Chain starts as s3=AA s2=BB s1=CC s0=DD; data packed {s3,s2,s1,s0}
        tbl[0] = '{4'b0100, 4'b0000, 1'b1, 8'hEE, 1'b0, 4'b0111, 32'h00BBCCDD, 4'd1, 4'd0};
        tbl[1] = '{4'b0000, 4'b0010, 1'b1, 8'hEE, 1'b0, 4'b1000, 32'hBB000000, 4'd0, 4'd1};
        tbl[2] = '{4'b1000, 4'b0010, 1'b1, 8'hEE, 1'b0, 4'b1100, 32'hAABB0000, 4'd1, 4'd1};
        tbl[3] = '{4'b0000, 4'b0000, 1'b1, 8'hEE, 1'b1, 4'b1111, 32'hBBCCDDEE, 4'd0, 4'd0};
        tbl[4] = '{4'b0001, 4'b0000, 1'b1, 8'hEE, 1'b0, 4'b1101, 32'hBBCC00DD, 4'd1, 4'd0};
        tbl[5] = '{4'b0000, 4'b1000, 1'b1, 8'hEE, 1'b0, 4'b0000, 32'h00000000, 4'd0, 4'd1};
        tbl[6] = '{4'b0000, 4'b0000, 1'b0, 8'hEE, 1'b1, 4'b1110, 32'hBBCCDD00, 4'd0, 4'd0};
        tbl[7] = '{4'b0010, 4'b0001, 1'b1, 8'hEE, 1'b0, 4'b1010, 32'hBB00CC00, 4'd1, 4'd1};

        // Reset state
        #1;
        chk("reset_valid", 32'(stage_valid), 32'h0);
        chk("reset_data", stage_data, 32'h0);
        chk("reset_occ", 32'(occupancy), 32'h0);

        // Plain streaming: first value emerges after four edges
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            rcycle(4'b0, 4'b0, 1'b1, 8'(8'h11 * n), 1'b0);
            chk("stream_out_valid", 32'(out_valid), 32'(n >= 4));
            chk("stream_out_data", 32'(out_data), (n >= 4) ? 32'(8'(8'h11 * (n - 3))) : 32'h0);
            chk("stream_occ", 32'(occupancy), (n < 4) ? n : 4);
        end

        // Table of single-cycle stall/flush events applied to a full chain
        for (int i = 0; i < 8; i++) begin
            fill_abcd();
            drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].id, 1'b0);
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("tbl%0d_valid", i), 32'(stage_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_data", i), stage_data, tbl[i].d);
            chk($sformatf("tbl%0d_stall_count", i), 32'(stall_count), 32'(tbl[i].sc));
            chk($sformatf("tbl%0d_flush_count", i), 32'(flush_count), 32'(tbl[i].fc));
        end

        // Counter saturation and clear priority over increment
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            rcycle(4'b0001, 4'b0, 1'b1, 8'($urandom), 1'b0);
            chk("sat_stall_count", 32'(stall_count), (i < 15) ? i : 15);
        end
        rcycle(4'b0001, 4'b0, 1'b1, 8'h00, 1'b1);
        chk("clear_stall_count", 32'(stall_count), 32'h0);

        // Asynchronous reset between edges while streaming
        do_reset();
        rcycle(4'b0, 4'b0, 1'b1, 8'h31, 1'b0);
        rcycle(4'b0, 4'b0, 1'b1, 8'h32, 1'b0);
        rcycle(4'b1000, 4'b0100, 1'b1, 8'h33, 1'b0);
        chk("pre_reset_stall_count", 32'(stall_count), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(stage_valid), 32'h0);
        chk("async_data", stage_data, 32'h0);
        chk("async_stall_count", 32'(stall_count), 32'h0);
        chk("async_flush_count", 32'(flush_count), 32'h0);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        rcycle(4'b0, 4'b0, 1'b1, 8'h5A, 1'b0);
        for (int n = 2; n <= 4; n++) begin
            rcycle(4'b0, 4'b0, 1'b0, 8'h00, 1'b0);
            chk("post_reset_out_valid", 32'(out_valid), 32'(n == 4));
        end
        chk("post_reset_out_data", 32'(out_data), 32'h5A);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] st;
            logic [3:0] fl;
            st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            fl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            rcycle(st, fl, 1'($urandom), 8'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
